// File: rtl/fft_inverse_butterfly.sv
// Two-stage inverse (Gentleman-Sande) butterfly: x_N = y_N + y_M, x_M = (y_N - y_M) * w_N.
// Define FFT_INV_SCALE_EN to halve both results (round toward -inf) before the output register.
module fft_inverse_butterfly #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] y_N,
  input  logic signed [DATA_WIDTH-1:0] y_M,
  input  logic signed [DATA_WIDTH-1:0] w_N,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic signed [DATA_WIDTH-1:0] x_N,
  output logic signed [DATA_WIDTH-1:0] x_M,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH + 1;

  logic                 s1_valid;
  logic signed [DW:0]   s1_sum;
  logic signed [DW:0]   s1_diff;
  logic signed [DW-1:0] s1_w;
  logic                 s1_last;

  logic s2_free;
  logic accept;
  logic advance;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pm;
  logic signed [PW-1:0] pm_sel;
  logic signed [DW:0]   sum_sel;
  logic                 sum_fits;
  logic                 pm_fits;

  // in_ready is held low while reset is asserted, then opens because S1 is empty.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  always_comb begin
    prod = PW'(s1_diff) * PW'(s1_w);
    pm   = prod >>> FRAC_BITS;
`ifdef FFT_INV_SCALE_EN
    sum_sel = s1_sum >>> 1;
    pm_sel  = pm >>> 1;
`else
    sum_sel = s1_sum;
    pm_sel  = pm;
`endif
    sum_fits = (sum_sel[DW] == sum_sel[DW-1]);
    pm_fits  = (pm_sel == {{(DW+1){pm_sel[DW-1]}}, pm_sel[DW-1:0]});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_diff  <= '0;
      s1_w     <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sum   <= (DW+1)'(y_N) + (DW+1)'(y_M);
      s1_diff  <= (DW+1)'(y_N) - (DW+1)'(y_M);
      s1_w     <= w_N;
      s1_last  <= in_last;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      x_N       <= '0;
      x_M       <= '0;
      ovf       <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= 1'b1;
        out_last  <= s1_last;
        x_N       <= sum_sel[DW-1:0];
        x_M       <= pm_sel[DW-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A fresh overflow beats a simultaneous clear.
      if (advance && !(sum_fits && pm_fits))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_inverse_butterfly.sv
// Self-checking bench for fft_inverse_butterfly (DATA_WIDTH=16, FRAC_BITS=14) with an integer reference model.
module tb_fft_inverse_butterfly;
  localparam int DW = 16;
  localparam int FB = 14;

`ifdef FFT_INV_SCALE_EN
  localparam int B_XN = 70,  B_XM = 30,  N_XN = 70,  N_XM = -30, C_XN = -2, C_XM = -2;
  localparam int O_XN = 16384, S_XN = -1, S_XM = -3;
  localparam bit O_OV = 1'b0;
`else
  localparam int B_XN = 140, B_XM = 60,  N_XN = 140, N_XM = -60, C_XN = -3, C_XM = -3;
  localparam int O_XN = -32768, S_XN = -1, S_XM = -6;
  localparam bit O_OV = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic signed [DW-1:0] y_N = '0, y_M = '0, w_N = '0;
  logic out_valid, out_ready = 1'b0, out_last, ovf, ovf_clr = 1'b0;
  logic signed [DW-1:0] x_N, x_M;

  fft_inverse_butterfly #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .y_N(y_N), .y_M(y_M), .w_N(w_N),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .x_N(x_N), .x_M(x_M), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] xn;
    logic [DW-1:0] xm;
    bit            last;
    bit            ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   pre_inflight;
  bit   acc;
  bit   ovf_exp = 1'b0;

  // Reference: plain integer arithmetic, floor division by 2^FB, range check against 16-bit signed.
  function automatic exp_t ref_pair(int yn, int ym, int w, bit last);
    exp_t   e;
    longint s, m;
    s = longint'(yn) + longint'(ym);
    m = ((longint'(yn) - longint'(ym)) * longint'(w)) >>> FB;
`ifdef FFT_INV_SCALE_EN
    s = s >>> 1;
    m = m >>> 1;
`endif
    e.xn   = s[DW-1:0];
    e.xm   = m[DW-1:0];
    e.last = last;
    e.ov   = (s > 32767) || (s < -32768) || (m > 32767) || (m < -32768);
    return e;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Drive one cycle's inputs, let in_ready settle, and record any accepted pair in the model.
  task automatic cycle(input bit v, input int yn, input int ym, input int w, input bit last, input bit ordy);
    @(negedge clk);
    in_valid  = v;
    y_N       = yn[DW-1:0];
    y_M       = ym[DW-1:0];
    w_N       = w[DW-1:0];
    in_last   = last;
    out_ready = ordy;
    #1;
    pre_inflight = exp_q.size();
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_pair(yn, ym, w, last));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || x_N !== 16'sd0 || x_M !== 16'sd0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b last=%b x_N=%0d x_M=%0d ovf=%b in_ready=%b, want all 0",
               out_valid, out_last, x_N, x_M, ovf, in_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    cycle(1, 100, 40, 16384, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: got out_valid=%b one edge after accept, want 0", out_valid);
    end
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || $signed(x_N) != B_XN || $signed(x_M) != B_XM || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%b x_N=%0d x_M=%0d ovf=%b, want 1 %0d %0d 0",
               out_valid, x_N, x_M, ovf, B_XN, B_XM);
    end
    $display("basic: x_N=%0d x_M=%0d", x_N, x_M);
    exp_q.delete();
  endtask

  task automatic test_twiddle();
    cycle(1, 100, 40, -16384, 0, 1);
    cycle(1, -3, 0, 16384, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || $signed(x_N) != N_XN || $signed(x_M) != N_XM) begin
      n_fail++;
      $display("FAIL neg_twiddle: got valid=%b x_N=%0d x_M=%0d, want 1 %0d %0d", out_valid, x_N, x_M, N_XN, N_XM);
    end
    $display("neg_twiddle: x_N=%0d x_M=%0d", x_N, x_M);
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || $signed(x_N) != C_XN || $signed(x_M) != C_XM) begin
      n_fail++;
      $display("FAIL round_neg: got valid=%b x_N=%0d x_M=%0d, want 1 %0d %0d", out_valid, x_N, x_M, C_XN, C_XM);
    end
    $display("round_neg: x_N=%0d x_M=%0d", x_N, x_M);
    exp_q.delete();
  endtask

  task automatic test_overflow();
    cycle(1, 32767, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ($signed(x_N) != O_XN || $signed(x_M) != 0 || ovf !== O_OV) begin
      n_fail++;
      $display("FAIL ovf_sum: got x_N=%0d x_M=%0d ovf=%b, want %0d 0 %b", x_N, x_M, ovf, O_XN, O_OV);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (ovf !== O_OV) begin
        n_fail++;
        $display("FAIL ovf_sticky: idle %0d got ovf=%b, want %b", i, ovf, O_OV);
      end
    end
    ovf_clr = 1'b1;
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", ovf);
    end
    // Keep the clear asserted while an overflowing pair lands in the output stage.
    cycle(1, 32767, -32768, 32767, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || $signed(x_N) != S_XN || $signed(x_M) != S_XM) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got ovf=%b x_N=%0d x_M=%0d, want 1 %0d %0d", ovf, x_N, x_M, S_XN, S_XM);
    end
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold_after_set: got ovf=%b, want 1", ovf);
    end
    ovf_clr = 1'b1;
    cycle(0, 0, 0, 0, 0, 1);
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear2: got ovf=%b, want 0", ovf);
    end
    $display("overflow: sticky/clear sequence done");
    exp_q.delete();
    ovf_exp = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   yn[8], ym[8], ww[8];
    int   idx, got, k;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      yn[i] = rnd16();
      ym[i] = rnd16();
      ww[i] = rnd16();
    end
    idx = 0;
    got = 0;
    for (int c = 1; c <= 30 && got < 8; c++) begin
      k = (idx < 8) ? idx : 7;
      cycle(idx < 8, yn[k], ym[k], ww[k], idx == 7, !(c >= 3 && c <= 5));
      n_cmp++;
      if (in_ready !== ((pre_inflight < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL b2b_in_ready: cycle %0d inflight=%0d got in_ready=%b, want %b",
                 c, pre_inflight, in_ready, (pre_inflight < 2) || out_ready);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (pre_inflight == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: got output x_N=%0d with nothing in flight, want none", x_N);
        end else begin
          e = exp_q.pop_front();
          ovf_exp |= e.ov;
          if (x_N !== e.xn || x_M !== e.xm || out_last !== e.last || ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL b2b_out%0d: got x_N=%0d x_M=%0d last=%b ovf=%b, want %0d %0d %b %b",
                     got, x_N, x_M, out_last, ovf, $signed(e.xn), $signed(e.xm), e.last, ovf_exp);
          end
          $display("b2b out %0d: x_N=%0d x_M=%0d last=%b", got, x_N, x_M, out_last);
          got++;
        end
      end
      if (acc) idx++;
    end
    n_cmp++;
    if (got != 8 || idx != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs from %0d accepts, want 8 and 8", got, idx);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    exp_t e;
    ovf_clr = 1'b1;
    cycle(0, 0, 0, 0, 0, 1);
    ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    for (int c = 0; c < 340; c++) begin
      cycle(c < 300 && $urandom_range(3) != 0, rnd16(), rnd16(), rnd16(), bit'($urandom_range(1)),
            c >= 300 || $urandom_range(9) < 7);
      n_cmp++;
      if (in_ready !== ((pre_inflight < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL rnd_in_ready: cycle %0d inflight=%0d got %b, want %b",
                 c, pre_inflight, in_ready, (pre_inflight < 2) || out_ready);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (pre_inflight == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious: cycle %0d got output with nothing in flight, want none", c);
        end else begin
          e = exp_q.pop_front();
          ovf_exp |= e.ov;
          if (x_N !== e.xn || x_M !== e.xm || out_last !== e.last || ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL rnd_out%0d: got x_N=%0d x_M=%0d last=%b ovf=%b, want %0d %0d %b %b",
                     n_out, x_N, x_M, out_last, ovf, $signed(e.xn), $signed(e.xm), e.last, ovf_exp);
          end
          $display("rnd out %0d: x_N=%0d x_M=%0d last=%b ovf=%b", n_out, x_N, x_M, out_last, ovf);
          n_out++;
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d pairs still pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    cycle(1, 1000, 200, 16384, 0, 0);
    cycle(1, 500, -70, 8192, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_setup: got out_valid=%b, want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || x_N !== 16'sd0 || x_M !== 16'sd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: got valid=%b x_N=%0d x_M=%0d last=%b in_ready=%b, want 0 0 0 0 0",
               out_valid, x_N, x_M, out_last, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midflight_stale: cycle %0d got out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
      end
    end
    $display("midflight reset: pipeline flushed");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_twiddle();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
